// File: rtl/vmu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vmu_mem_responder
// Function : Splits VMU line load/store requests into BUS_WIDTH beats on a
//            single-outstanding word bus and reassembles load data.
//            Define VMU_RSP_STORE_ACK_EN to make stores return a response.
// Revision : 1.0 - initial release
// ============================================================================
module vmu_mem_responder #(
  parameter int REQ_DATA_WIDTH = 256,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int VECTOR_LANES   = 8,
  parameter int MICROOP_WIDTH  = 5,
  localparam int TW            = $clog2(VECTOR_LANES) + 1,
  // mem_req_i = {address, microop, ticket, data}; mem_resp_o = {ticket, data}
  localparam int REQ_WIDTH     = ADDR_WIDTH + MICROOP_WIDTH + TW + REQ_DATA_WIDTH,
  localparam int RESP_WIDTH    = TW + REQ_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req_valid_i,
  input  logic [REQ_WIDTH-1:0]  mem_req_i,
  output logic                  cache_ready_o,
  output logic                  mem_resp_valid_o,
  output logic [RESP_WIDTH-1:0] mem_resp_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [BUS_WIDTH-1:0]  bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [BUS_WIDTH-1:0]  bus_rdata_i
);

  localparam int BEATS = REQ_DATA_WIDTH / BUS_WIDTH;
  localparam int LB    = $clog2(REQ_DATA_WIDTH / 8);
  localparam int BB    = $clog2(BUS_WIDTH / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0]            last_beat_c     = CW'(BEATS - 1);
  localparam logic [MICROOP_WIDTH-1:0] opcode_vload_c  = MICROOP_WIDTH'(1);
  localparam logic [MICROOP_WIDTH-1:0] opcode_vstore_c = MICROOP_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [TW-1:0]             ticket_q;
  logic [REQ_DATA_WIDTH-1:0] line_q;
  logic [CW-1:0]             cnt_q;

  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [MICROOP_WIDTH-1:0]  req_op;
  logic [TW-1:0]             req_ticket;
  logic [REQ_DATA_WIDTH-1:0] req_data;
  logic                      is_load, is_store, active, beat_done, last_beat;
  logic                      unused_addr_bits;

  assign {req_addr, req_op, req_ticket, req_data} = mem_req_i;
  assign unused_addr_bits = ^req_addr[LB-1:0];

  assign is_load   = (req_op == opcode_vload_c);
  assign is_store  = (req_op == opcode_vstore_c);
  assign active    = (state_q == LOAD) || (state_q == STORE);
  assign beat_done = active && bus_ack_i;
  assign last_beat = (cnt_q == last_beat_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    cache_ready_o    = 1'b0;
    bus_req_o        = 1'b0;
    bus_we_o         = 1'b0;
    mem_resp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cache_ready_o = 1'b1;
        // Unknown microops are consumed here without touching the bus.
        if (mem_req_valid_i) begin
          if (is_load)       state_d = LOAD;
          else if (is_store) state_d = STORE;
        end
      end
      LOAD: begin
        bus_req_o = 1'b1;
        if (bus_ack_i && last_beat) state_d = RESP;
      end
      STORE: begin
        bus_req_o = 1'b1;
        bus_we_o  = 1'b1;
`ifdef VMU_RSP_STORE_ACK_EN
        if (bus_ack_i && last_beat) state_d = RESP;
`else
        if (bus_ack_i && last_beat) state_d = IDLE;
`endif
      end
      RESP: begin
        mem_resp_valid_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line alignment of base guarantees the beat offset never carries out of the line.
  assign bus_addr_o  = active ? (base_q + (ADDR_WIDTH'(cnt_q) << BB)) : '0;
  assign bus_wdata_o = active ? line_q[cnt_q*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign mem_resp_o  = {ticket_q, line_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      ticket_q <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (state_q == IDLE && mem_req_valid_i && (is_load || is_store)) begin
        base_q   <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
        ticket_q <= req_ticket;
        cnt_q    <= '0;
        if (is_store) line_q <= req_data;
      end
      if (beat_done) begin
        if (state_q == LOAD) line_q[cnt_q*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata_i;
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
`ifdef VMU_RSP_STORE_ACK_EN
        // Store acknowledgements carry an all-zero payload.
        if (state_q == STORE && last_beat) line_q <= '0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vmu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmu_mem_responder
// Function : Scoreboard bench for vmu_mem_responder with a bus memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vmu_mem_responder;
  localparam int RDW = 256, BW = 32, AW = 32, VL = 8, MW = 5, TW = 4, BEATS = 8;
  localparam int REQW = AW + MW + TW + RDW, RESPW = TW + RDW;
  localparam logic [MW-1:0] OP_LD = 5'h01, OP_ST = 5'h02, OP_BAD = 5'h1F;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             mem_req_valid_i = 1'b0;
  logic [REQW-1:0]  mem_req_i = '0;
  logic             cache_ready_o, mem_resp_valid_o, bus_req_o, bus_we_o;
  logic [RESPW-1:0] mem_resp_o;
  logic [AW-1:0]    bus_addr_o;
  logic [BW-1:0]    bus_wdata_o;
  logic             bus_ack_i = 1'b0;
  logic [BW-1:0]    bus_rdata_i = '0;

  vmu_mem_responder #(.REQ_DATA_WIDTH(RDW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
                      .VECTOR_LANES(VL), .MICROOP_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid_i(mem_req_valid_i), .mem_req_i(mem_req_i),
    .cache_ready_o(cache_ready_o),
    .mem_resp_valid_o(mem_resp_valid_o), .mem_resp_o(mem_resp_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0, checks = 0;
  int stall_mode = 0;   // >=0: fixed wait cycles per beat, -1: random 0..3
  int beats_done = 0;

  typedef struct { logic [RESPW-1:0] resp; int due; } exp_resp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [BW-1:0] wdata; } exp_beat_t;
  exp_resp_t resp_q[$];
  exp_beat_t beat_q[$];
  logic [BW-1:0] mem [logic [AW-1:0]];

  task automatic check(input string name, input logic [RESPW-1:0] act, input logic [RESPW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Bus slave: checks each beat against the expected beat list, holds stalls.
  initial begin : bus_slave
    logic in_beat; int wait_left; exp_beat_t cur, e;
    in_beat = 1'b0; wait_left = 0;
    forever begin
      @(negedge clk);
      bus_ack_i   = 1'b0;
      bus_rdata_i = $urandom;
      if (rst_n && bus_req_o) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          cur.we = bus_we_o; cur.addr = bus_addr_o; cur.wdata = bus_wdata_o;
          wait_left = (stall_mode >= 0) ? stall_mode : int'($urandom_range(0, 3));
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %0h we %0b, expected no bus activity", bus_addr_o, bus_we_o);
          end else begin
            e = beat_q.pop_front();
            check("beat_addr", RESPW'(bus_addr_o), RESPW'(e.addr));
            check("beat_we", RESPW'(bus_we_o), RESPW'(e.we));
            if (e.we) check("beat_wdata", RESPW'(bus_wdata_o), RESPW'(e.wdata));
          end
        end else begin
          check("beat_stable", RESPW'({bus_we_o, bus_addr_o, bus_wdata_o}),
                RESPW'({cur.we, cur.addr, cur.wdata}));
        end
        if (wait_left == 0) begin
          bus_ack_i = 1'b1;
          if (bus_we_o) mem[bus_addr_o] = bus_wdata_o;
          else          bus_rdata_i = mem_rd(bus_addr_o);
          in_beat = 1'b0;
          beats_done++;
        end else begin
          wait_left--;
        end
      end else begin
        in_beat = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && mem_resp_valid_o) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got %0h, expected no response", mem_resp_o);
      end else begin
        exp_resp_t e;
        e = resp_q.pop_front();
        check("resp", mem_resp_o, e.resp);
        if (e.due >= 0) check("resp_cycle", RESPW'(cyc), RESPW'(e.due));
      end
    end
  end

  task automatic issue(input logic [MW-1:0] op, input logic [AW-1:0] addr,
                       input logic [TW-1:0] tkt, input logic [RDW-1:0] data, output int hs);
    logic [AW-1:0] base; logic [RDW-1:0] line; exp_beat_t b; exp_resp_t r; int n;
    @(negedge clk);
    base = addr & ~(AW'(RDW/8 - 1));
    mem_req_i = {addr, op, tkt, data};
    mem_req_valid_i = 1'b1;
    n = 0;
    while (cache_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles, expected acceptance", n);
      mem_req_valid_i = 1'b0; hs = -1;
      return;
    end
    hs = cyc;
    line = '0;
    if (op == OP_LD || op == OP_ST) begin
      for (int k = 0; k < BEATS; k++) begin
        b.we = (op == OP_ST);
        b.addr = base + AW'(4*k);
        b.wdata = (op == OP_ST) ? data[k*BW +: BW] : '0;
        beat_q.push_back(b);
        line[k*BW +: BW] = mem_rd(base + AW'(4*k));
      end
      r.due = (stall_mode >= 0) ? hs + BEATS*(stall_mode + 1) + 1 : -1;
      if (op == OP_LD) begin
        r.resp = {tkt, line}; resp_q.push_back(r);
      end
`ifdef VMU_RSP_STORE_ACK_EN
      else begin
        r.resp = {tkt, {RDW{1'b0}}}; resp_q.push_back(r);
      end
`endif
    end
    @(posedge clk);
    #1;
    mem_req_valid_i = 1'b0;
    mem_req_i = REQW'({10{32'($urandom)}});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0 || cache_ready_o !== 1'b1) && n < 600) begin
      @(negedge clk); n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending responses, expected 0", resp_q.size());
    end
  endtask

  function automatic logic [RDW-1:0] rand_line();
    logic [RDW-1:0] d;
    for (int k = 0; k < BEATS; k++) d[k*BW +: BW] = $urandom;
    return d;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hs, hs2, n;
    logic [RDW-1:0] d;
    logic [MW-1:0] op;
    int r;

    #1;
    check("rst_ready", RESPW'(cache_ready_o), RESPW'(1'b1));
    check("rst_bus_req", RESPW'({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}), '0);
    check("rst_resp", RESPW'(mem_resp_valid_o), '0);
    check("rst_resp_data", mem_resp_o, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait load: beat k returns 0xA0+k
    for (int k = 0; k < BEATS; k++) mem[32'h1040 + 4*k] = 32'hA0 + k;
    stall_mode = 0;
    issue(OP_LD, 32'h0000_1044, 4'd5, rand_line(), hs);
    wait_idle();

    // Store word k = k, then read the line back
    for (int k = 0; k < BEATS; k++) d[k*BW +: BW] = k;
    issue(OP_ST, 32'h0000_2000, 4'd3, d, hs);
    wait_idle();
    issue(OP_LD, 32'h0000_2010, 4'd7, rand_line(), hs);
    wait_idle();

    // Three-cycle stall per beat
    stall_mode = 3;
    issue(OP_LD, 32'h0000_1044, 4'd2, rand_line(), hs);
    wait_idle();
    issue(OP_ST, 32'h0000_2400, 4'd9, rand_line(), hs);
    wait_idle();

    // Request waiting while busy is accepted the cycle after RESP
    stall_mode = 0;
    issue(OP_LD, 32'h0000_2400, 4'd1, rand_line(), hs);
    issue(OP_LD, 32'h0000_1040, 4'd4, rand_line(), hs2);
    check("b2b_accept_gap", RESPW'(hs2 - hs), RESPW'(BEATS + 2));
    wait_idle();

    // Illegal microop: accepted, no bus activity, no response
    issue(OP_BAD, 32'h0000_3000, 4'd6, rand_line(), hs);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("illegal_idle", RESPW'({cache_ready_o, bus_req_o, mem_resp_valid_o}), RESPW'(3'b100));
    end

    // Reset on beat 4 of a load
    beats_done = 0;
    issue(OP_LD, 32'h0000_2000, 4'd8, rand_line(), hs);
    n = 0;
    while (beats_done < 4 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bus", RESPW'({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}), '0);
    check("async_rst_ready", RESPW'({cache_ready_o, mem_resp_valid_o}), RESPW'(2'b10));
    check("async_rst_resp_data", mem_resp_o, '0);
    resp_q.delete();
    beat_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < BEATS; k++) mem[32'h2000 + 4*k] = 32'h5500 + k;
    issue(OP_LD, 32'h0000_2000, 4'd10, rand_line(), hs);
    wait_idle();

    // Randomized traffic with random stalls
    stall_mode = -1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      op = OP_LD;
      else if (r < 9) op = OP_ST;
      else            op = MW'($urandom_range(3, 31));
      issue(op, 32'h3000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31)),
            TW'($urandom), rand_line(), hs);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("resp_queue_drained", RESPW'(resp_q.size()), '0);
    check("beat_queue_drained", RESPW'(beat_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
